wb_qpi_bridge: RTL and testbench



---
 rtl/wb_qpi_bridge.sv | 198 +++++++++++++++++++
 tb/tb_wb_qpi_bridge.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_qpi_bridge.sv
// wb_qpi_bridge: Wishbone B4 pipelined slave that issues word transfers on the
// QPI memory request interface. Word-addressed Wishbone accesses become byte
// addressed QPI requests; one request is buffered while another is in flight.
// Optional build macro: BURST_MERGE_EN - when defined, back-to-back sequential
// same-direction accesses continue the open QPI burst instead of reopening it.
module wb_qpi_bridge #(
  parameter int AW = 23,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wb_cyc,
  input  logic          i_wb_stb,
  input  logic          i_wb_we,
  input  logic [AW-1:0] i_wb_addr,
  input  logic [3:0]    i_wb_sel,
  input  logic [DW-1:0] i_wb_data,
  output logic          o_wb_stall,
  output logic          o_wb_ack,
  output logic [DW-1:0] o_wb_data,
  output logic          qpi_do_read,
  output logic          qpi_do_write,
  output logic [24:0]   qpi_addr,
  output logic [DW-1:0] qpi_wdata,
  input  logic [DW-1:0] qpi_rdata,
  input  logic          qpi_next_word,
  input  logic          qpi_is_idle
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    FINISH
  } bridgeState_t;

  bridgeState_t r_state;
  bridgeState_t w_stateNext;

  logic          r_bufValid;
  logic          r_bufWe;
  logic [AW-1:0] r_bufAddr;
  logic [DW-1:0] r_bufData;
  logic          r_curWe;
  logic          r_abort;

  logic          w_accept;
  logic          w_popIdle;
  logic          w_continue;
  logic          w_endBurst;
  logic          w_wordDone;
  logic [AW+1:0] w_byteAddr;
  logic          w_unusedSel;

  // Full words are always written, so the byte selects carry no information.
  assign w_unusedSel = ^i_wb_sel;

  assign w_accept   = i_wb_cyc & i_wb_stb & ~r_bufValid;
  assign o_wb_stall = r_bufValid;
  assign w_byteAddr = {r_bufAddr, 2'b00};

`ifdef BURST_MERGE_EN
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);

  logic [AW-1:0] r_curAddr;
  logic          w_canMerge;

  // A buffered request may extend the burst only if it is the very next word
  // in the same direction, the burst would not wrap, and the cycle is alive.
  assign w_canMerge = r_bufValid && (r_bufWe == r_curWe) &&
                      (r_bufAddr == r_curAddr + ADDR_ONE) &&
                      (r_curAddr != '1) && i_wb_cyc && !r_abort;

  // Track the word address of the word currently on the QPI bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_curAddr <= '0;
    end else if (w_popIdle) begin
      r_curAddr <= r_bufAddr;
    end else if (w_continue) begin
      r_curAddr <= r_curAddr + ADDR_ONE;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic and the per-cycle control strobes for the datapath.
  always_comb begin
    w_stateNext = r_state;
    w_popIdle   = 1'b0;
    w_continue  = 1'b0;
    w_endBurst  = 1'b0;
    w_wordDone  = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_bufValid && i_wb_cyc && qpi_is_idle) begin
          w_popIdle   = 1'b1;
          w_stateNext = XFER;
        end
      end
      XFER: begin
        if (qpi_next_word) begin
          w_wordDone = 1'b1;
`ifdef BURST_MERGE_EN
          if (w_canMerge) begin
            w_continue = 1'b1;
          end else begin
            w_endBurst  = 1'b1;
            w_stateNext = FINISH;
          end
`else
          w_endBurst  = 1'b1;
          w_stateNext = FINISH;
`endif
        end
      end
      FINISH: begin
        if (qpi_is_idle) begin
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Single-entry request buffer; dropping the cycle discards whatever it holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bufValid <= 1'b0;
      r_bufWe    <= 1'b0;
      r_bufAddr  <= '0;
      r_bufData  <= '0;
    end else if (!i_wb_cyc) begin
      r_bufValid <= 1'b0;
    end else if (w_accept) begin
      r_bufValid <= 1'b1;
      r_bufWe    <= i_wb_we;
      r_bufAddr  <= i_wb_addr;
      r_bufData  <= i_wb_data;
    end else if (w_popIdle || w_continue) begin
      r_bufValid <= 1'b0;
    end
  end

  // QPI request side: open a burst from the buffer, feed continuation words,
  // and remember whether the Wishbone master walked away mid-transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      qpi_do_read  <= 1'b0;
      qpi_do_write <= 1'b0;
      qpi_addr     <= '0;
      qpi_wdata    <= '0;
      r_curWe      <= 1'b0;
      r_abort      <= 1'b0;
    end else begin
      if (w_popIdle) begin
        qpi_addr     <= 25'(w_byteAddr);
        qpi_wdata    <= r_bufData;
        qpi_do_read  <= !r_bufWe;
        qpi_do_write <= r_bufWe;
        r_curWe      <= r_bufWe;
        r_abort      <= 1'b0;
      end else if ((r_state == XFER) && !i_wb_cyc) begin
        r_abort <= 1'b1;
      end
      if (w_continue) begin
        qpi_wdata <= r_bufData;
      end
      if (w_endBurst) begin
        qpi_do_read  <= 1'b0;
        qpi_do_write <= 1'b0;
      end
    end
  end

  // Wishbone response: one ack per completed word unless the cycle was abandoned.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_wb_ack  <= 1'b0;
      o_wb_data <= '0;
    end else begin
      o_wb_ack <= w_wordDone && i_wb_cyc && !r_abort;
      if (w_wordDone && !r_curWe) begin
        o_wb_data <= qpi_rdata;
      end
    end
  end

endmodule

// File: tb/tb_wb_qpi_bridge.sv
// tb_wb_qpi_bridge: self-checking bench for wb_qpi_bridge. A behavioural QPI
// memory answers bursts with configurable latency; a reference memory and an
// expected-response queue predict every Wishbone ack. Honours BURST_MERGE_EN.
`timescale 1ns/1ps
module tb_wb_qpi_bridge;

  localparam int AW = 23;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_wb_cyc, i_wb_stb, i_wb_we;
  logic [22:0] i_wb_addr;
  logic [3:0]  i_wb_sel;
  logic [31:0] i_wb_data;
  logic        o_wb_stall, o_wb_ack;
  logic [31:0] o_wb_data;
  logic        qpi_do_read, qpi_do_write;
  logic [24:0] qpi_addr;
  logic [31:0] qpi_wdata, qpi_rdata;
  logic        qpi_next_word, qpi_is_idle;

  wb_qpi_bridge #(.AW(AW), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_addr(i_wb_addr), .i_wb_sel(i_wb_sel), .i_wb_data(i_wb_data),
    .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_data(o_wb_data),
    .qpi_do_read(qpi_do_read), .qpi_do_write(qpi_do_write),
    .qpi_addr(qpi_addr), .qpi_wdata(qpi_wdata), .qpi_rdata(qpi_rdata),
    .qpi_next_word(qpi_next_word), .qpi_is_idle(qpi_is_idle)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [31:0] data; } expAck_t;
  typedef struct { logic [24:0] addr; logic [31:0] wdata; logic we; } burst_t;
  typedef struct {
    logic        we;
    logic [22:0] addr;
    logic [31:0] wdata;
    logic [31:0] expData;
    logic [24:0] expQpiAddr;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  expAck_t     expQ[$];
  burst_t      burstQ[$];
  vec_t        tbl[7];
  logic [31:0] devMem[int];
  logic [31:0] refMem[int];

  int   memPhase, memCnt, memWord, memIdx, wordsDone;
  logic [24:0] memBase;
  logic memDirWr;
  bit   randomMode, holdBusy, spurious;

  int   ackCnt, burstCnt, addrChanges, badAcks, bothHigh;
  logic prevDo;
  logic [24:0] heldAddr;
  expAck_t monEntry;

  function automatic logic [31:0] initVal(input int idx);
    return (32'(idx) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] devRead(input int idx);
    if (devMem.exists(idx)) return devMem[idx];
    return initVal(idx);
  endfunction

  function automatic logic [31:0] refRead(input int idx);
    if (refMem.exists(idx)) return refMem[idx];
    return initVal(idx);
  endfunction

  function automatic int pickLat();
    if (randomMode) return int'($urandom_range(0, 4));
    return 5;
  endfunction

  function automatic int pickTail();
    if (randomMode) return int'($urandom_range(0, 3));
    return 1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drive one request at a negedge once the slave is not stalling; optionally
  // record the expected response in the reference model.
  task automatic applyStimulus(input logic we, input logic [22:0] addr, input logic [31:0] data, input bit track);
    int guard = 0;
    while (o_wb_stall && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) checkOutput("stallTimeout", {31'd0, o_wb_stall}, 32'd0);
    i_wb_cyc  = 1'b1;
    i_wb_stb  = 1'b1;
    i_wb_we   = we;
    i_wb_addr = addr;
    i_wb_data = data;
    i_wb_sel  = 4'hF;
    if (track) begin
      if (we) begin
        refMem[int'(addr)] = data;
        expQ.push_back('{1'b1, data});
      end else begin
        expQ.push_back('{1'b0, refRead(int'(addr))});
      end
    end
    @(negedge clk);
    i_wb_stb = 1'b0;
  endtask

  task automatic waitAllAcks(input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("pendingAcks", 32'(expQ.size()), 32'd0);
  endtask

  task automatic waitQuiet();
    int n = 0;
    while ((memPhase != 0 || qpi_do_read || qpi_do_write || o_wb_stall || !qpi_is_idle) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("quietReached", {31'd0, (n < 200)}, 32'd1);
    @(negedge clk);
    @(negedge clk);
  endtask

  // Behavioural QPI memory: latency per word, next wdata taken after each
  // pulse, burst closes when do_* is low the cycle after a pulse.
  initial begin
    qpi_next_word = 1'b0;
    qpi_is_idle   = 1'b1;
    qpi_rdata     = 32'd0;
    memPhase = 0; memCnt = 0; memWord = 0; wordsDone = 0;
    memBase = '0; memDirWr = 1'b0;
    forever begin
      @(negedge clk);
      qpi_next_word = 1'b0;
      if (rst) begin
        memPhase    = 0;
        qpi_is_idle = 1'b1;
      end else begin
        case (memPhase)
          0: begin
            qpi_is_idle = !holdBusy;
            if (spurious) begin
              qpi_next_word = 1'b1;
              spurious = 1'b0;
            end else if (!holdBusy && (qpi_do_read || qpi_do_write)) begin
              memBase     = qpi_addr;
              memDirWr    = qpi_do_write;
              memWord     = 0;
              memCnt      = pickLat();
              memPhase    = 1;
              qpi_is_idle = 1'b0;
            end
          end
          1: begin
            if (memCnt > 0) begin
              memCnt--;
            end else begin
              qpi_next_word = 1'b1;
              memIdx = int'(memBase >> 2) + memWord;
              if (memDirWr) devMem[memIdx] = qpi_wdata;
              else qpi_rdata = devRead(memIdx);
              memWord++;
              wordsDone++;
              memPhase = 2;
            end
          end
          2: begin
            if (memDirWr ? qpi_do_write : qpi_do_read) begin
              memCnt   = pickLat();
              memPhase = 1;
            end else begin
              memCnt   = pickTail();
              memPhase = 3;
            end
          end
          default: begin
            if (memCnt > 0) begin
              memCnt--;
            end else begin
              qpi_is_idle = 1'b1;
              memPhase    = 0;
            end
          end
        endcase
      end
    end
  end

  // Monitor: records bursts, checks address stability and scores every ack.
  initial begin
    ackCnt = 0; burstCnt = 0; addrChanges = 0; badAcks = 0; bothHigh = 0;
    prevDo = 1'b0; heldAddr = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (qpi_do_read && qpi_do_write) bothHigh++;
        if ((qpi_do_read || qpi_do_write) && !prevDo) begin
          burstQ.push_back('{qpi_addr, qpi_wdata, qpi_do_write});
          burstCnt++;
          heldAddr = qpi_addr;
        end else if ((qpi_do_read || qpi_do_write) && (qpi_addr != heldAddr)) begin
          addrChanges++;
        end
        if (o_wb_ack) begin
          ackCnt++;
          if (ackCnt > wordsDone) badAcks++;
          checkOutput("ackExpected", {31'd0, (expQ.size() > 0)}, 32'd1);
          if (expQ.size() > 0) begin
            monEntry = expQ.pop_front();
            if (!monEntry.we) checkOutput("ackReadData", o_wb_data, monEntry.data);
          end
        end
      end
      prevDo = qpi_do_read || qpi_do_write;
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int b0, a0, n, r;
    logic [22:0] a;
    logic we;

    tbl[0] = '{1'b1, 23'h7FFFFF, 32'h12345678, 32'h00000000, 25'h1FFFFFC};
    tbl[1] = '{1'b0, 23'h000010, 32'h00000000, 32'hDEADBEEF, 25'h0000040};
    tbl[2] = '{1'b0, 23'h7FFFFF, 32'h00000000, 32'h12345678, 25'h1FFFFFC};
    tbl[3] = '{1'b1, 23'h000000, 32'hA5A5A5A5, 32'h00000000, 25'h0000000};
    tbl[4] = '{1'b0, 23'h000000, 32'h00000000, 32'hA5A5A5A5, 25'h0000000};
    tbl[5] = '{1'b1, 23'h000100, 32'hCAFEF00D, 32'h00000000, 25'h0000400};
    tbl[6] = '{1'b0, 23'h000100, 32'h00000000, 32'hCAFEF00D, 25'h0000400};

    randomMode = 0; holdBusy = 0; spurious = 0;
    rst = 1'b1;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    i_wb_addr = '0; i_wb_sel = 4'h0; i_wb_data = '0;
    devMem[32'h10] = 32'hDEADBEEF;
    refMem[32'h10] = 32'hDEADBEEF;

    repeat (3) @(negedge clk);
    checkOutput("rstStall", {31'd0, o_wb_stall}, 32'd0);
    checkOutput("rstAck", {31'd0, o_wb_ack}, 32'd0);
    checkOutput("rstRdata", o_wb_data, 32'd0);
    checkOutput("rstDoRead", {31'd0, qpi_do_read}, 32'd0);
    checkOutput("rstDoWrite", {31'd0, qpi_do_write}, 32'd0);
    checkOutput("rstQpiAddr", {7'd0, qpi_addr}, 32'd0);
    checkOutput("rstWdata", qpi_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] table-driven single accesses");
    for (int i = 0; i < 7; i++) begin
      b0 = burstCnt;
      applyStimulus(tbl[i].we, tbl[i].addr, tbl[i].wdata, 1'b1);
      n = 0;
      while (!o_wb_ack && n < 100) begin
        @(negedge clk);
        n++;
      end
      checkOutput("tblAckSeen", {31'd0, o_wb_ack}, 32'd1);
      if (!tbl[i].we) checkOutput("tblReadData", o_wb_data, tbl[i].expData);
      checkOutput("tblDoLowAtAck", {30'd0, qpi_do_read, qpi_do_write}, 32'd0);
      @(negedge clk);
      checkOutput("tblAckOneCycle", {31'd0, o_wb_ack}, 32'd0);
      waitQuiet();
      checkOutput("tblBurstCount", 32'(burstCnt - b0), 32'd1);
      checkOutput("tblQpiAddr", {7'd0, burstQ[burstCnt-1].addr}, {7'd0, tbl[i].expQpiAddr});
      checkOutput("tblBurstDir", {31'd0, burstQ[burstCnt-1].we}, {31'd0, tbl[i].we});
      if (tbl[i].we) begin
        checkOutput("tblBurstWdata", burstQ[burstCnt-1].wdata, tbl[i].wdata);
        checkOutput("tblMemWrite", devRead(int'(tbl[i].addr)), tbl[i].wdata);
      end
    end

    $display("[TB] stray next_word while idle");
    a0 = ackCnt; b0 = burstCnt;
    spurious = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("strayNoAck", 32'(ackCnt - a0), 32'd0);
    checkOutput("strayNoBurst", 32'(burstCnt - b0), 32'd0);

    $display("[TB] memory busy holds off the request");
    holdBusy = 1'b1;
    repeat (2) @(negedge clk);
    b0 = burstCnt;
    applyStimulus(1'b0, 23'h000030, 32'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      checkOutput("holdNoReq", {30'd0, qpi_do_read, qpi_do_write}, 32'd0);
      checkOutput("holdStall", {31'd0, o_wb_stall}, 32'd1);
      @(negedge clk);
    end
    holdBusy = 1'b0;
    waitAllAcks(100);
    waitQuiet();
    checkOutput("holdBurstCount", 32'(burstCnt - b0), 32'd1);
    checkOutput("holdQpiAddr", {7'd0, burstQ[b0].addr}, 32'h000000C0);

    $display("[TB] four pipelined sequential reads");
    b0 = burstCnt;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 23'(32'h100 + i), 32'd0, 1'b1);
    waitAllAcks(300);
    waitQuiet();
`ifdef BURST_MERGE_EN
    checkOutput("seqBurstCount", 32'(burstCnt - b0), 32'd1);
`else
    checkOutput("seqBurstCount", 32'(burstCnt - b0), 32'd4);
    checkOutput("seqSecondAddr", {7'd0, burstQ[b0+1].addr}, 32'h00000404);
`endif
    checkOutput("seqFirstAddr", {7'd0, burstQ[b0].addr}, 32'h00000400);

    $display("[TB] non-sequential reads");
    b0 = burstCnt;
    applyStimulus(1'b0, 23'h000100, 32'd0, 1'b1);
    applyStimulus(1'b0, 23'h000200, 32'd0, 1'b1);
    waitAllAcks(300);
    waitQuiet();
    checkOutput("jumpBurstCount", 32'(burstCnt - b0), 32'd2);
    checkOutput("jumpSecondAddr", {7'd0, burstQ[b0+1].addr}, 32'h00000800);

    $display("[TB] writes across the address wrap");
    b0 = burstCnt;
    applyStimulus(1'b1, 23'h7FFFFF, 32'h01020304, 1'b1);
    applyStimulus(1'b1, 23'h000000, 32'h05060708, 1'b1);
    waitAllAcks(300);
    waitQuiet();
    checkOutput("wrapBurstCount", 32'(burstCnt - b0), 32'd2);
    checkOutput("wrapSecondAddr", {7'd0, burstQ[b0+1].addr}, 32'h00000000);
    checkOutput("wrapMemTop", devRead(32'h7FFFFF), 32'h01020304);
    checkOutput("wrapMemZero", devRead(0), 32'h05060708);

    $display("[TB] cycle dropped during a write");
    b0 = burstCnt; a0 = ackCnt;
    applyStimulus(1'b1, 23'h000020, 32'h0BADCAFE, 1'b0);
    applyStimulus(1'b1, 23'h000021, 32'h11112222, 1'b0);
    checkOutput("abortInXfer", {31'd0, qpi_do_write}, 32'd1);
    i_wb_cyc = 1'b0;
    i_wb_stb = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("abortNoAck", 32'(ackCnt - a0), 32'd0);
    checkOutput("abortBurstCount", 32'(burstCnt - b0), 32'd1);
    checkOutput("abortWriteLanded", devRead(32'h20), 32'h0BADCAFE);
    checkOutput("abortBufDropped", devRead(32'h21), initVal(32'h21));
    checkOutput("abortStallLow", {31'd0, o_wb_stall}, 32'd0);
    checkOutput("abortDoLow", {30'd0, qpi_do_read, qpi_do_write}, 32'd0);
    checkOutput("abortMemIdle", 32'(memPhase), 32'd0);
    refMem[32'h20] = 32'h0BADCAFE;

    $display("[TB] randomized traffic");
    randomMode = 1;
    a = 23'h000300;
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4) a = a + 23'd1;
      else if (r < 8) a = 23'h000300 + 23'($urandom_range(0, 15));
      else if (r == 8) a = 23'h7FFFFF;
      else a = 23'h000000;
      we = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      applyStimulus(we, a, $urandom, 1'b1);
    end
    waitAllAcks(3000);
    waitQuiet();

    checkOutput("addrStableInBurst", 32'(addrChanges), 32'd0);
    checkOutput("ackWithoutWord", 32'(badAcks), 32'd0);
    checkOutput("readAndWriteTogether", 32'(bothHigh), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
